// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle add/sub/logic/pass ops plus an optional iterative
// shift-add multiplier compiled in only when ALU_MULTICYCLE_MUL_EN is defined.
module alu_multicycle #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       select,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             z_flag,
    output logic             c_flag,
    output logic             n_flag
);

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_MUL    = 3'b010,
        OP_PASS_A = 3'b011,
        OP_PASS_B = 3'b100,
        OP_AND    = 3'b101,
        OP_OR     = 3'b110,
        OP_NOP    = 3'b111
    } op_e;

    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_wr;

    assign accept = in_valid && in_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_wr    = 1'b1;
        case (op_e'(select))
            OP_ADD:    {alu_carry, alu_res} = {1'b0, A} + {1'b0, B};
            OP_SUB:    {alu_carry, alu_res} = {1'b0, B} - {1'b0, A};
            OP_PASS_A: alu_res = A;
            OP_PASS_B: alu_res = B;
            OP_AND:    alu_res = A & B;
            OP_OR:     alu_res = A | B;
            default:   alu_wr  = 1'b0;
        endcase
    end

`ifdef ALU_MULTICYCLE_MUL_EN
    typedef enum logic {S_IDLE, S_MUL_BUSY} state_e;

    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e             state;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   iter;

    assign in_ready = (state == S_IDLE);
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // NOTE: the multiplier datapath is not reset; it is always reloaded on accept, so only control state needs it.
    always_ff @(posedge clk) begin
        if (state == S_MUL_BUSY) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
        end
    end
`else
    assign in_ready = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            z_flag    <= 1'b0;
            c_flag    <= 1'b0;
            n_flag    <= 1'b0;
`ifdef ALU_MULTICYCLE_MUL_EN
            state     <= S_IDLE;
            iter      <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
`ifdef ALU_MULTICYCLE_MUL_EN
            if (state == S_MUL_BUSY) begin
                iter <= iter + 1'b1;
                if (iter == LAST_ITER) begin
                    out       <= acc_next[WIDTH-1:0];
                    z_flag    <= (acc_next[WIDTH-1:0] == '0);
                    c_flag    <= |acc_next[2*WIDTH-1:WIDTH];
                    n_flag    <= acc_next[WIDTH-1];
                    out_valid <= 1'b1;
                    state     <= S_IDLE;
                end
            end
            if (accept && op_e'(select) == OP_MUL) begin
                state <= S_MUL_BUSY;
                iter  <= '0;
            end
`endif
            if (accept && alu_wr) begin
                out       <= alu_res;
                z_flag    <= (alu_res == '0);
                c_flag    <= alu_carry;
                n_flag    <= alu_res[WIDTH-1];
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=16); MUL vectors follow
// whether ALU_MULTICYCLE_MUL_EN is defined for the build.
module tb_alu_multicycle;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       select;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             z_flag;
    logic             c_flag;
    logic             n_flag;

    int checks = 0;
    int errors = 0;

    alu_multicycle #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .select    (select),
        .out       (out),
        .out_valid (out_valid),
        .z_flag    (z_flag),
        .c_flag    (c_flag),
        .n_flag    (n_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one op at the negedge, release in_valid just after the accepting edge.
    task automatic do_op(input logic [2:0] sel, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        select   = sel;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        select   = 3'b000;
        A        = 16'hDEAD;
        B        = 16'hBEEF;
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] r,
                                input logic z, input logic c, input logic n);
        check({tag, "_out"}, out, r);
        check({tag, "_z"}, z_flag, z);
        check({tag, "_c"}, c_flag, c);
        check({tag, "_n"}, n_flag, n);
        check({tag, "_vld"}, out_valid, 1'b1);
    endtask

    task automatic check_pulse_end(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_vld_end"}, out_valid, 1'b0);
    endtask

    // Count busy cycles while confirming outputs hold; bounded so a stuck FSM cannot hang.
    task automatic wait_mul(input logic [WIDTH-1:0] held, output int n);
        n = 0;
        while (!in_ready && n < 40) begin
            check("busy_vld", out_valid, 1'b0);
            check("busy_hold", out, held);
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    int  busy;
    logic saw_valid;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        select   = 3'b000;
        A        = '0;
        B        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", out, 16'd0);
        check("rst_vld", out_valid, 1'b0);
        check("rst_flags", {z_flag, c_flag, n_flag}, 3'b000);
        check("rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3'b000, 16'd60, 16'd62);
        check_result("add", 16'd122, 1'b0, 1'b0, 1'b0);
        check_pulse_end("add");

        do_op(3'b000, 16'hFFFF, 16'd2);
        check_result("add_carry", 16'd1, 1'b0, 1'b1, 1'b0);

        do_op(3'b001, 16'd40, 16'd40);
        check_result("sub_eq", 16'd0, 1'b1, 1'b0, 1'b0);
        do_op(3'b001, 16'd40, 16'd20);
        check_result("sub_borrow", 16'hFFEC, 1'b0, 1'b1, 1'b1);

        do_op(3'b101, 16'hF0F0, 16'h0FF0);
        check_result("and", 16'h00F0, 1'b0, 1'b0, 1'b0);
        do_op(3'b110, 16'hF0F0, 16'h0FF0);
        check_result("or", 16'hFFF0, 1'b0, 1'b0, 1'b1);
        do_op(3'b011, 16'h8000, 16'd7);
        check_result("pass_a", 16'h8000, 1'b0, 1'b0, 1'b1);

        do_op(3'b100, 16'd40, 16'd20);
        check_result("pass_b", 16'd20, 1'b0, 1'b0, 1'b0);
        do_op(3'b111, 16'd40, 16'd99);
        check("nop_out", out, 16'd20);
        check("nop_flags", {z_flag, c_flag, n_flag}, 3'b000);
        check("nop_vld", out_valid, 1'b0);
        check("nop_ready", in_ready, 1'b1);

`ifdef ALU_MULTICYCLE_MUL_EN
        do_op(3'b010, 16'd40, 16'd40);
        check("mul_ready_low", in_ready, 1'b0);
        wait_mul(16'd20, busy);
        check("mul_latency", busy, 16);
        check_result("mul", 16'd1600, 1'b0, 1'b0, 1'b0);
        check_pulse_end("mul");

        do_op(3'b010, 16'h0100, 16'h0100);
        wait_mul(16'd1600, busy);
        check("mul_ovf_latency", busy, 16);
        check_result("mul_ovf", 16'd0, 1'b1, 1'b1, 1'b0);
        // Accept a new op in the same cycle the MUL result is valid.
        do_op(3'b000, 16'd1, 16'd1);
        check_result("b2b_add", 16'd2, 1'b0, 1'b0, 1'b0);

        do_op(3'b010, 16'd3, 16'd5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_out", out, 16'd0);
        check("abort_vld", out_valid, 1'b0);
        check("abort_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            saw_valid = saw_valid | out_valid;
        end
        check("abort_no_vld", saw_valid, 1'b0);
        do_op(3'b000, 16'd1, 16'd1);
        check_result("post_abort_add", 16'd2, 1'b0, 1'b0, 1'b0);
`else
        do_op(3'b010, 16'd40, 16'd40);
        check("mul_off_out", out, 16'd20);
        check("mul_off_flags", {z_flag, c_flag, n_flag}, 3'b000);
        check("mul_off_vld", out_valid, 1'b0);
        saw_valid = 1'b0;
        repeat (20) begin
            check("mul_off_ready", in_ready, 1'b1);
            @(posedge clk);
            #1;
            saw_valid = saw_valid | out_valid;
        end
        check("mul_off_no_vld", saw_valid, 1'b0);
        check("mul_off_hold", out, 16'd20);
`endif

        // Reset wins over a simultaneous request.
        do_op(3'b100, 16'd0, 16'd77);
        check_result("pre_rst", 16'd77, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        select   = 3'b000;
        A        = 16'd5;
        B        = 16'd5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rst_prio_out", out, 16'd0);
        check("rst_prio_vld", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_prio_after_out", out, 16'd0);
        check("rst_prio_after_vld", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width (minimum 4).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port in_valid  input  1  operation request.
REQ-005 The block SHALL have port in_ready  output  1  block can accept an operation this cycle.
REQ-006 The block SHALL have ports A and B, each input WIDTH wide, operands.
REQ-007 The block SHALL have port select  input  3  opcode.
REQ-008 The block SHALL have port out  output  WIDTH  registered result.
REQ-009 The block SHALL have port out_valid  output  1  one-cycle pulse, result and flags updated.
REQ-010 The block SHALL have ports z_flag, c_flag and n_flag, each output 1, registered zero, carry/borrow/overflow and negative flags.

Function
REQ-011 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; A, B and select SHALL be captured at accept.
REQ-012 Opcodes SHALL be: 000 ADD A+B; 001 SUB B-A; 010 MUL A*B; 011 pass A; 100 pass B; 101 AND; 110 OR; 111 NOP.
REQ-013 Single-cycle ops (all except MUL and NOP) SHALL update out and flags on the accept edge, with out_valid=1 for the following cycle only.
REQ-014 ADD SHALL set c_flag to the carry out of bit WIDTH-1; SUB SHALL set c_flag=1 when A>B (borrow); all other ops SHALL set c_flag=0, except MUL (REQ-019).
REQ-015 z_flag SHALL be 1 iff the WIDTH-bit result is zero, and n_flag SHALL equal result bit WIDTH-1, for every non-NOP op.
REQ-016 NOP SHALL be accepted, SHALL leave out and all flags holding their previous values, and SHALL NOT assert out_valid.
REQ-017 The FSM SHALL have states IDLE and MUL_BUSY; IDLE SHALL go to MUL_BUSY on accept of MUL; MUL_BUSY SHALL go to IDLE after exactly WIDTH iterations.
REQ-018 MUL SHALL be an iterative shift-add of one bit per cycle, with in_ready=0 in MUL_BUSY and in_ready=1 in IDLE.
REQ-019 MUL SHALL write out to the low WIDTH bits of the product and set c_flag=1 if the upper WIDTH bits are nonzero; out_valid SHALL pulse WIDTH+1 cycles after accept.
REQ-020 out, flags and out_valid SHALL hold their previous values during MUL_BUSY until completion.
REQ-021 in_valid, A, B and select SHALL be ignored while in_ready=0; a new op MAY be accepted in the same cycle out_valid is high for MUL.

Reset
REQ-022 When rst_n=0 at a rising edge, the block SHALL set out=0, z_flag=0, c_flag=0, n_flag=0, out_valid=0, and FSM=IDLE (in_ready=1 after reset).
REQ-023 Reset during MUL_BUSY SHALL abort the multiply; no out_valid SHALL be produced for the aborted op.
REQ-024 rst_n=0 SHALL take priority over a simultaneous in_valid; that op SHALL NOT be accepted.

Configuration
REQ-025 With macro ALU_MULTICYCLE_MUL_EN defined, the iterative multiplier and MUL_BUSY state SHALL be compiled in and behave as in REQ-017 to REQ-019.
REQ-026 Without ALU_MULTICYCLE_MUL_EN, opcode 010 SHALL behave as NOP (REQ-016), in_ready SHALL be constantly 1 outside reset, and no multiplier logic SHALL be synthesised.

Verification (WIDTH=16, ALU_MULTICYCLE_MUL_EN defined unless stated)
REQ-027 ADD A=60 B=62 -> next cycle out=122, z=0, c=0, n=0, out_valid pulses for 1 cycle.
REQ-028 SUB A=40 B=40 -> out=0, z=1, c=0; then SUB A=40 B=20 -> out=0xFFEC, c=1, n=1.
REQ-029 MUL A=40 B=40 -> in_ready=0 for 16 cycles, out=1600 with out_valid 17 cycles after accept; MUL A=0x0100 B=0x0100 -> out=0, z=1, c=1.
REQ-030 pass B with B=20, then NOP with A=40 B=99 -> out stays 20, flags unchanged, no out_valid on the NOP.
REQ-031 MUL A=3 B=5, then rst_n=0 on cycle 5 -> out=0, no out_valid, in_ready=1; a subsequent ADD 1+1 gives out=2.
REQ-032 Build without ALU_MULTICYCLE_MUL_EN: MUL A=40 B=40 -> out holds, no out_valid, in_ready stays 1.
